// File: rtl/pipe_ctrl_if.sv
// Data-bus handshake between pipe_ctrl (master) and the memory side (slave).
interface pipe_ctrl_if;
  logic lsu_req;     // request to the data bus
  logic lsu_gnt;     // bus accepted the request
  logic lsu_rvalid;  // bus response valid

  modport master (output lsu_req, input lsu_gnt, input lsu_rvalid);
  modport slave  (input lsu_req, output lsu_gnt, output lsu_rvalid);
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing for the milano core.
// Drives IF/ID and ID/EX hold/flush controls and owns the data-bus handshake
// for the LSU op in EX. It also resolves load-use hazards and turns a taken
// branch into a two-stage flush.
// Optional feature: define PIPE_CTRL_TIMEOUT_EN to abort LSU transactions
// that wait LSU_TIMEOUT cycles. Abort sets the sticky lsu_err_o flag.
module pipe_ctrl #(
  parameter int unsigned LSU_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic              id_rs1_used_i,
  input  logic [4:0]        id_rs2_addr_i,
  input  logic              id_rs2_used_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic              ex_rd_wr_en_i,
  input  logic              ex_lsu_req_i,
  input  logic              ex_lsu_we_i,
  input  logic              branch_taken_i,
  pipe_ctrl_if.master       lsu,
  output logic              if_stall_o,
  output logic              id_ex_stall_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              lsu_err_o,
  output logic [31:0]       stall_cnt_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP} lsu_state_e;

  lsu_state_e  state_q, state_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        abort;
  logic        lsu_stall;
  logic        load_use;

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(LSU_TIMEOUT);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;

  // The wait counter counts every cycle of a transaction, starting with the issue
  // cycle. With LSU_TIMEOUT=N the stall therefore lasts at most N cycles.
  always_comb begin
    abort      = (state_q != IDLE) && (wait_cnt_q == TMO);
    wait_cnt_d = 8'd0;
    if (state_q == IDLE) wait_cnt_d = ex_lsu_req_i ? 8'd1 : 8'd0;
    else if (!abort)     wait_cnt_d = wait_cnt_q + 8'd1;
    err_d = err_q | abort;
  end

  // Timeout state; the error flag is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign lsu_err_o = err_q;
`else
  localparam logic [7:0] TMO = 8'(LSU_TIMEOUT);
  logic unused_tmo;
  assign unused_tmo = ^TMO;
  assign abort      = 1'b0;
  assign lsu_err_o  = 1'b0;
`endif

  // LSU handshake next state plus the saturating stall counter.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (ex_lsu_req_i) state_d = lsu.lsu_gnt ? WAIT_RESP : WAIT_GNT;
      WAIT_GNT:  if (lsu.lsu_gnt)  state_d = WAIT_RESP;
      WAIT_RESP: if (lsu.lsu_rvalid) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;

    stall_cnt_d = stall_cnt_q;
    if (id_ex_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Handshake FSM and stall counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Pipeline controls. The LSU stall overrides everything, and a branch overrides load-use.
  // On an abort, the request is dropped along with the stall so the bus
  // does not see a request that nobody will wait for.
  always_comb begin
    lsu.lsu_req = !abort && (((state_q == IDLE) && ex_lsu_req_i) || (state_q == WAIT_GNT));
    lsu_stall   = ex_lsu_req_i && !((state_q == WAIT_RESP) && lsu.lsu_rvalid) && !abort;
    load_use    = ex_lsu_req_i && !ex_lsu_we_i && ex_rd_wr_en_i && (ex_rd_addr_i != 5'd0) &&
                  ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                   (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));
    if_stall_o    = lsu_stall || (!branch_taken_i && load_use);
    id_ex_stall_o = lsu_stall;
    if_id_flush_o = !lsu_stall && branch_taken_i;
    id_ex_flush_o = !lsu_stall && (branch_taken_i || load_use);
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Inputs change at posedge+1, and checks run at posedge+3.
module tb_pipe_ctrl;
`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic        id_rs1_used_i, id_rs2_used_i, ex_rd_wr_en_i;
  logic        ex_lsu_req_i, ex_lsu_we_i, branch_taken_i;
  logic        if_stall_o, id_ex_stall_o, if_id_flush_o, id_ex_flush_o, lsu_err_o;
  logic [31:0] stall_cnt_o;
  int          tests = 0;
  int          fails = 0;
  int          bad;

  pipe_ctrl_if bus();

  pipe_ctrl #(.LSU_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_wr_en_i(ex_rd_wr_en_i),
    .ex_lsu_req_i(ex_lsu_req_i), .ex_lsu_we_i(ex_lsu_we_i),
    .branch_taken_i(branch_taken_i), .lsu(bus.master),
    .if_stall_o(if_stall_o), .id_ex_stall_o(id_ex_stall_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
    .lsu_err_o(lsu_err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {lsu_req, if_stall, id_ex_stall, if_id_flush, id_ex_flush, lsu_err}
  logic [5:0] outs;
  assign outs = {bus.lsu_req, if_stall_o, id_ex_stall_o, if_id_flush_o, id_ex_flush_o, lsu_err_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ex(input logic req, input logic we, input logic [4:0] rd, input logic wen);
    ex_lsu_req_i = req; ex_lsu_we_i = we; ex_rd_addr_i = rd; ex_rd_wr_en_i = wen;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
    id_rs1_addr_i = rs1; id_rs1_used_i = u1; id_rs2_addr_i = rs2; id_rs2_used_i = u2;
  endtask

  task automatic set_bus(input logic gnt, input logic rv);
    bus.lsu_gnt = gnt; bus.lsu_rvalid = rv;
  endtask

  // One-cycle-grant, one-cycle-response LSU op; hz is the expected load-use bubble on completion.
  task automatic fast_op(input string tag, input logic we, input logic [4:0] rd, input logic hz);
    set_ex(1'b1, we, rd, 1'b1); set_bus(1'b1, 1'b0);
    #2 chk({tag, "_issue"}, 32'(outs), 32'(6'b111000));
    cyc(); set_bus(1'b0, 1'b1);
    #2 chk({tag, "_done"}, 32'(outs), hz ? 32'(6'b010010) : 32'(6'b000000));
    cyc(); set_ex(1'b0, 1'b0, 5'd0, 1'b0); set_bus(1'b0, 1'b0);
    #2 chk({tag, "_after"}, 32'(outs), 32'(6'b000000));
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    set_ex(1'b0, 1'b0, 5'd0, 1'b0); set_id(5'd0, 1'b0, 5'd0, 1'b0);
    set_bus(1'b0, 1'b0); branch_taken_i = 1'b0;
    #3;
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_scnt", stall_cnt_o, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    cyc();

    // Load: grant on issue, rvalid after three empty response cycles.
    set_ex(1'b1, 1'b0, 5'd5, 1'b1); set_bus(1'b1, 1'b0);
    #2 chk("ld_issue", 32'(outs), 32'(6'b111000));
    cyc(); set_bus(1'b0, 1'b0);
    #2 chk("ld_wait1", 32'(outs), 32'(6'b011000));
    cyc(); #2 chk("ld_wait2", 32'(outs), 32'(6'b011000));
    cyc(); #2 chk("ld_wait3", 32'(outs), 32'(6'b011000));
    cyc(); set_bus(1'b0, 1'b1);
    #2 chk("ld_rvalid", 32'(outs), 32'(6'b000000));
    chk("ld_scnt", stall_cnt_o, 32'd4);
    cyc(); set_ex(1'b0, 1'b0, 5'd0, 1'b0); set_bus(1'b0, 1'b0);
    #2 chk("ld_idle", 32'(outs), 32'(6'b000000));
    chk("ld_scnt2", stall_cnt_o, 32'd4);
    cyc();

    // Load-use through rs2, then x0 destination, a store, and a rs1 match.
    set_id(5'd0, 1'b0, 5'd5, 1'b1);
    fast_op("lu_rs2", 1'b0, 5'd5, 1'b1);
    chk("lu_scnt", stall_cnt_o, 32'd5);
    set_id(5'd0, 1'b1, 5'd0, 1'b1);
    fast_op("lu_x0", 1'b0, 5'd0, 1'b0);
    set_id(5'd7, 1'b1, 5'd0, 1'b0);
    fast_op("st_nohz", 1'b1, 5'd7, 1'b0);
    fast_op("lu_rs1", 1'b0, 5'd7, 1'b1);
    set_id(5'd7, 1'b0, 5'd7, 1'b0);
    fast_op("lu_unused", 1'b0, 5'd7, 1'b0);
    chk("lu_scnt2", stall_cnt_o, 32'd9);
    set_id(5'd0, 1'b0, 5'd0, 1'b0);

    // Taken branch with no LSU op.
    branch_taken_i = 1'b1;
    #2 chk("br_flush", 32'(outs), 32'(6'b000110));
    cyc(); branch_taken_i = 1'b0;
    #2 chk("br_after", 32'(outs), 32'(6'b000000));
    cyc();

    // Grant withheld two cycles, with an illegal branch and a stray rvalid.
    set_ex(1'b1, 1'b0, 5'd3, 1'b1); set_bus(1'b0, 1'b0); branch_taken_i = 1'b1;
    #2 chk("gw_issue_br", 32'(outs), 32'(6'b111000));
    cyc(); branch_taken_i = 1'b0; set_bus(1'b0, 1'b1);
    #2 chk("gw_wgnt_rv", 32'(outs), 32'(6'b111000));
    cyc(); set_bus(1'b1, 1'b0);
    #2 chk("gw_gnt", 32'(outs), 32'(6'b111000));
    cyc(); set_bus(1'b0, 1'b1);
    #2 chk("gw_rvalid", 32'(outs), 32'(6'b000000));
    chk("gw_scnt", stall_cnt_o, 32'd12);
    cyc(); set_ex(1'b0, 1'b0, 5'd0, 1'b0); set_bus(1'b0, 1'b0);
    cyc();

    // Grant never arrives.
    set_ex(1'b1, 1'b0, 5'd4, 1'b1);
    #2 chk("to_issue", 32'(outs), 32'(6'b111000));
`ifdef PIPE_CTRL_TIMEOUT_EN
    cyc(); #2 chk("to_w1", 32'(outs), 32'(6'b111000));
    cyc(); #2 chk("to_w2", 32'(outs), 32'(6'b111000));
    cyc(); #2 chk("to_w3", 32'(outs), 32'(6'b111000));
    cyc(); #2 chk("to_abort", 32'(outs), 32'(6'b000000));
    cyc(); set_ex(1'b0, 1'b0, 5'd0, 1'b0);
    #2 chk("to_err", 32'(outs), 32'(6'b000001));
    cyc(); #2 chk("to_err_sticky", 32'(outs), 32'(6'b000001));
    chk("to_scnt", stall_cnt_o, 32'd16);
    cyc();
`else
    bad = 0;
    for (int i = 0; i < 119; i++) begin
      cyc(); #2;
      if (outs !== 6'b111000) bad++;
    end
    chk("hold_120", 32'(bad), 32'd0);
    cyc(); set_bus(1'b1, 1'b0);
    #2 chk("hold_gnt", 32'(outs), 32'(6'b111000));
    cyc(); set_bus(1'b0, 1'b1);
    #2 chk("hold_rvalid", 32'(outs), 32'(6'b000000));
    chk("hold_scnt", stall_cnt_o, 32'd133);
    cyc(); set_ex(1'b0, 1'b0, 5'd0, 1'b0); set_bus(1'b0, 1'b0);
    cyc();
`endif

    // Reset pulse during WAIT_RESP.
    set_ex(1'b1, 1'b0, 5'd6, 1'b1); set_bus(1'b1, 1'b0);
    #2 chk("rs_issue", 32'(outs), 32'(6'b111000));
    cyc(); set_bus(1'b0, 1'b0);
    #2 chk("rs_wresp", 32'(outs), 32'(6'b011000));
    #1 set_ex(1'b0, 1'b0, 5'd0, 1'b0); rst_ni = 1'b0;
    #1 chk("rs_async_outs", 32'(outs), 32'd0);
    chk("rs_async_scnt", stall_cnt_o, 32'd0);
    cyc(); rst_ni = 1'b1;
    cyc(); set_bus(1'b0, 1'b1);
    #2 chk("rs_stray_rv", 32'(outs), 32'(6'b000000));
    cyc(); set_bus(1'b0, 1'b0); set_ex(1'b1, 1'b0, 5'd6, 1'b1);
    #2 chk("rs_idle_issue", 32'(outs), 32'(6'b111000));
    cyc(); set_bus(1'b1, 1'b0);
    #2 chk("rs_gnt", 32'(outs), 32'(6'b111000));
    cyc(); set_bus(1'b0, 1'b1);
    #2 chk("rs_done", 32'(outs), 32'(6'b000000));
    cyc(); set_ex(1'b0, 1'b0, 5'd0, 1'b0); set_bus(1'b0, 1'b0);
    #2 chk("rs_scnt", stall_cnt_o, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
